// File: rtl/sr_cond_pkg.sv
// Shared types, default parameters and counter sizing for the SR input conditioner.
package sr_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_HOLD  = 2'd2
  } sr_state_e;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_PULSE_W    = 1;
  localparam int DEF_HOLDOFF    = 2;

  // Bits needed for a counter that runs 0 .. n-1 (never narrower than 1).
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge detect for one raw request.
module sr_debounce
  import sr_cond_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int            CW       = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // The level flips on the DEB_CYCLES-th consecutive disagreeing sample.
  always_comb begin
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/sr_input_conditioner.sv
// Debounces raw set/reset requests and issues mutually exclusive s/r pulses to an SR flip-flop.
// Define SR_ALT_PRIORITY_EN to grant alternating commands on conflict instead of dropping both.
module sr_input_conditioner
  import sr_cond_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int PULSE_W    = DEF_PULSE_W,
  parameter int HOLDOFF    = DEF_HOLDOFF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_req,
  input  logic rst_req,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict,
  output logic last_cmd
);

  localparam int            PH_MAX = (PULSE_W > HOLDOFF) ? PULSE_W : HOLDOFF;
  localparam int            CW     = cnt_w(PH_MAX);
  localparam logic [CW-1:0] P_LAST = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] H_LAST = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  logic set_lvl, set_rise, rst_lvl, rst_rise;

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk(clk), .rst_n(rst_n), .din(set_req), .level(set_lvl), .rise(set_rise)
  );

  sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
    .clk(clk), .rst_n(rst_n), .din(rst_req), .level(rst_lvl), .rise(rst_rise)
  );

  sr_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s_q, s_d, r_q, r_d;
  logic          conf_q, conf_d, last_q, last_d;
  logic          pend_set_q, pend_set_d, pend_rst_q, pend_rst_d;
  logic          ready, grant_set, grant_rst;
`ifdef SR_ALT_PRIORITY_EN
  logic          tog_q, tog_d;
`endif

  // The cycle that ends PULSE/HOLD doubles as an IDLE dispatch slot, so
  // back-to-back pulses start exactly PULSE_W+HOLDOFF cycles apart.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    s_d        = s_q;
    r_d        = r_q;
    conf_d     = 1'b0;
    last_d     = last_q;
    pend_set_d = pend_set_q | (set_rise & set_lvl);
    pend_rst_d = pend_rst_q | (rst_rise & rst_lvl);
    ready      = 1'b0;
    grant_set  = 1'b0;
    grant_rst  = 1'b0;
`ifdef SR_ALT_PRIORITY_EN
    tog_d      = tog_q;
`endif
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_PULSE: begin
        if (cnt_q == P_LAST) begin
          s_d   = 1'b0;
          r_d   = 1'b0;
          cnt_d = '0;
          if (HOLDOFF == 0) begin
            state_d = ST_IDLE;
            ready   = 1'b1;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == H_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          ready   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ready) begin
      if (pend_set_d && pend_rst_d) begin
        conf_d = 1'b1;
`ifdef SR_ALT_PRIORITY_EN
        grant_set = ~tog_q;
        grant_rst = tog_q;
        tog_d     = ~tog_q;
`endif
      end else begin
        grant_set = pend_set_d;
        grant_rst = pend_rst_d;
      end
      pend_set_d = 1'b0;
      pend_rst_d = 1'b0;
      if (grant_set || grant_rst) begin
        state_d = ST_PULSE;
        cnt_d   = '0;
        s_d     = grant_set;
        r_d     = grant_rst;
        last_d  = grant_set;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      conf_q     <= 1'b0;
      last_q     <= 1'b0;
      pend_set_q <= 1'b0;
      pend_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s_q        <= s_d;
      r_q        <= r_d;
      conf_q     <= conf_d;
      last_q     <= last_d;
      pend_set_q <= pend_set_d;
      pend_rst_q <= pend_rst_d;
    end
  end

`ifdef SR_ALT_PRIORITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tog_q <= 1'b0;
    else        tog_q <= tog_d;
  end
`endif

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = (state_q != ST_IDLE);
  assign conflict = conf_q;
  assign last_cmd = last_q;

endmodule

// File: tb/tb_sr_input_conditioner.sv
// Bench for sr_input_conditioner: default build plus a DEB=1/PULSE_W=3/HOLDOFF=0 instance,
// both compared every cycle against a time-based reference model.
module tb_sr_input_conditioner;

  localparam int NC   = 2;
  localparam int MAXN = 8192;
  localparam int DEB0 = 4, PW0 = 1, HO0 = 2;
  localparam int DEB1 = 1, PW1 = 3, HO1 = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic set_req = 1'b0;
  logic rst_req = 1'b0;
  logic [NC-1:0] s_o, r_o, busy_o, conf_o, last_o;

  always #5 clk = ~clk;

  sr_input_conditioner #(.DEB_CYCLES(DEB0), .PULSE_W(PW0), .HOLDOFF(HO0)) dut0 (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .rst_req(rst_req),
    .s(s_o[0]), .r(r_o[0]), .busy(busy_o[0]), .conflict(conf_o[0]), .last_cmd(last_o[0])
  );

  sr_input_conditioner #(.DEB_CYCLES(DEB1), .PULSE_W(PW1), .HOLDOFF(HO1)) dut1 (
    .clk(clk), .rst_n(rst_n), .set_req(set_req), .rst_req(rst_req),
    .s(s_o[1]), .r(r_o[1]), .busy(busy_o[1]), .conflict(conf_o[1]), .last_cmd(last_o[1])
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc;

  bit rawS [MAXN];
  bit rawR [MAXN];

  bit lvS [NC], lvR [NC], rsS [NC], rsR [NC], pS [NC], pR [NC];
  bit last [NC], conf [NC], tog [NC], isset [NC];
  int start [NC], free_at [NC], first_s [NC];

  function automatic int pdeb(input int c); return (c == 0) ? DEB0 : DEB1; endfunction
  function automatic int ppw(input int c);  return (c == 0) ? PW0  : PW1;  endfunction
  function automatic int pho(input int c);  return (c == 0) ? HO0  : HO1;  endfunction

  function automatic bit rawv(input bit is_set, input int n);
    if (n < 0) return 1'b0;
    return is_set ? rawS[n] : rawR[n];
  endfunction

  // Level flips at edge n when the DEB synchronised samples seen by edges
  // n-DEB+1..n (raw samples n-DEB-1..n-2) all disagree with it.
  function automatic bit deb_flip(input int c, input bit is_set, input bit lv, input int n);
    for (int k = 2; k <= pdeb(c) + 1; k++)
      if (rawv(is_set, n - k) == lv) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    cyc = 0;
    for (int c = 0; c < NC; c++) begin
      lvS[c] = 0; lvR[c] = 0; rsS[c] = 0; rsR[c] = 0; pS[c] = 0; pR[c] = 0;
      last[c] = 0; conf[c] = 0; tog[c] = 0; isset[c] = 0;
      start[c] = -100; free_at[c] = 0; first_s[c] = -1;
    end
  endtask

  task automatic model_edge(input int c);
    bit eS, eR, gS, gR, fS, fR;
    eS = pS[c] | rsS[c];
    eR = pR[c] | rsR[c];
    conf[c] = 1'b0;
    if (cyc >= free_at[c]) begin
      gS = 1'b0;
      gR = 1'b0;
      if (eS && eR) begin
        conf[c] = 1'b1;
`ifdef SR_ALT_PRIORITY_EN
        gS = !tog[c];
        gR = tog[c];
        tog[c] = !tog[c];
`endif
      end else begin
        gS = eS;
        gR = eR;
      end
      eS = 1'b0;
      eR = 1'b0;
      if (gS || gR) begin
        start[c]   = cyc;
        free_at[c] = cyc + ppw(c) + pho(c);
        isset[c]   = gS;
        last[c]    = gS;
      end
    end
    pS[c] = eS;
    pR[c] = eR;
    fS = deb_flip(c, 1'b1, lvS[c], cyc);
    fR = deb_flip(c, 1'b0, lvR[c], cyc);
    rsS[c] = fS && !lvS[c];
    rsR[c] = fR && !lvR[c];
    if (fS) lvS[c] = !lvS[c];
    if (fR) lvR[c] = !lvR[c];
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input int c);
    bit act;
    act = (cyc >= start[c]) && (cyc < start[c] + ppw(c));
    chk($sformatf("dut%0d.s", c),        s_o[c],    act && isset[c]);
    chk($sformatf("dut%0d.r", c),        r_o[c],    act && !isset[c]);
    chk($sformatf("dut%0d.busy", c),     busy_o[c], cyc < free_at[c]);
    chk($sformatf("dut%0d.conflict", c), conf_o[c], conf[c]);
    chk($sformatf("dut%0d.last_cmd", c), last_o[c], last[c]);
    chk($sformatf("dut%0d.s_and_r", c),  s_o[c] & r_o[c], 1'b0);
    if (s_o[c] === 1'b1 && first_s[c] < 0) first_s[c] = cyc;
  endtask

  task automatic tick(input bit sv, input bit rv);
    set_req = sv;
    rst_req = rv;
    rawS[cyc] = sv;
    rawR[cyc] = rv;
    @(posedge clk);
    for (int c = 0; c < NC; c++) model_edge(c);
    @(negedge clk);
    for (int c = 0; c < NC; c++) check_dut(c);
    cyc++;
  endtask

  task automatic check_reset_outputs();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("rst%0d.s", c),        s_o[c],    1'b0);
      chk($sformatf("rst%0d.r", c),        r_o[c],    1'b0);
      chk($sformatf("rst%0d.busy", c),     busy_o[c], 1'b0);
      chk($sformatf("rst%0d.conflict", c), conf_o[c], 1'b0);
      chk($sformatf("rst%0d.last_cmd", c), last_o[c], 1'b0);
    end
  endtask

  initial begin
    bit seen;
    bit sv, rv;
    int len;

    // Power-on reset
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    model_reset();

    // Single set held high: latency DEB+2 edges
    repeat (12) tick(1'b1, 1'b0);
    repeat (8)  tick(1'b0, 1'b0);
    chk_i("latency0", first_s[0], DEB0 + 2);
    chk_i("latency1", first_s[1], DEB1 + 2);

    // Short glitch
    repeat (3)  tick(1'b1, 1'b0);
    repeat (10) tick(1'b0, 1'b0);

    // Set, then reset event landing during HOLD
    repeat (3)  tick(1'b1, 1'b0);
    repeat (8)  tick(1'b1, 1'b1);
    repeat (10) tick(1'b0, 1'b0);

    // Two simultaneous set/reset conflicts
    repeat (2) begin
      repeat (10) tick(1'b1, 1'b1);
      repeat (10) tick(1'b0, 1'b0);
    end

    // Asynchronous reset while s is high
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick(1'b1, 1'b0);
      seen = (s_o[0] === 1'b1);
    end
    chk("mid_pulse_seen", seen, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (4)  tick(1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b1);
    repeat (6)  tick(1'b0, 1'b0);

    // Random request levels with random hold lengths
    for (int i = 0; i < 300; i++) begin
      sv  = 1'($urandom_range(0, 1));
      rv  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 10);
      repeat (len) tick(sv, rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
